// File: rtl/user_irq_pkg.sv
// user_irq_pkg: shared definitions for the user interrupt router.
//   reg_addr_e  - register select on the configuration port
//   FAST_BASE   - first source index routed to the fast-irq fan-out
//   ext_base()  - first external source index for a given fast count
//   ext_mask()  - 32-bit mask of the sources that take part in claim/complete
package user_irq_pkg;

  typedef enum logic [1:0] {
    REG_EN    = 2'd0,
    REG_MODE  = 2'd1,
    REG_PEND  = 2'd2,
    REG_CLAIM = 2'd3
  } reg_addr_e;

  localparam int FAST_BASE = 2;

  function automatic int ext_base(input int num_fast);
    return num_fast + FAST_BASE;
  endfunction

  // Sources at or above ext_base() and below num_src are external.
  function automatic logic [31:0] ext_mask(input int num_src, input int num_fast);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i >= ext_base(num_fast) && i < num_src) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/user_irq_prio_enc.sv
// user_irq_prio_enc: lowest-index-first priority encoder.
//   req   - request vector
//   valid - at least one request bit is set
//   id    - index of the lowest set request bit (0 when none)
module user_irq_prio_enc #(
  parameter int NUM_SRC = 32,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scanning from the top down lets the lowest set index overwrite last.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/user_irq_router.sv
// user_irq_router: routes SoC irq sources onto a user core's interrupt pins.
// Per-source enable, edge/level mode, pending latch, fast-irq fan-out, and a
// claim/complete handshake with in-service gating for external sources.
//
// Ports:
//   clk_i, rst_i        - clock, synchronous active-high reset
//   irq_i               - raw sources, synchronous to clk_i
//   cfg_we_i/cfg_re_i   - register write / read strobes
//   cfg_addr_i          - 0 EN, 1 MODE, 2 PEND (W1C), 3 CLAIM (read=claim, write=complete)
//   cfg_wdata_i         - write data
//   cfg_rdata_o         - read data
//   cfg_rvalid_o        - read data valid
//   irq_timer_o         - source 0
//   irq_software_o      - source 1
//   irq_fast_o          - bit k from source k+2
//   irq_external_o      - any claimable external source
//
// Register port handshake: there is no back-pressure. A read strobe accepted
// at an edge is always answered at the next edge with cfg_rvalid_o=1 for one
// cycle and cfg_rdata_o holding the value; cfg_rdata_o is 0 whenever
// cfg_rvalid_o is 0. Writes take effect at the edge where cfg_we_i is high;
// a simultaneous read returns the pre-write value. Reset drops any read.
module user_irq_router
  import user_irq_pkg::*;
#(
  parameter int NUM_SRC  = 32,
  parameter int NUM_FAST = 15,
  parameter int ID_W     = $clog2(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               cfg_we_i,
  input  logic               cfg_re_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic               cfg_rvalid_o,
  output logic               irq_timer_o,
  output logic               irq_software_o,
  output logic [14:0]        irq_fast_o,
  output logic               irq_external_o
);

  localparam logic [31:0]        EXT_MASK32 = ext_mask(NUM_SRC, NUM_FAST);
  localparam logic [NUM_SRC-1:0] EXT_MASK   = EXT_MASK32[NUM_SRC-1:0];

  logic [NUM_SRC-1:0] en, mode, pend, insv, prev;

  reg_addr_e          addr;
  logic               cpl_hit, claim_hit;
  logic [ID_W-1:0]    cpl_id;
  logic [NUM_SRC-1:0] cpl_vec, claim_vec, insv_after_cpl, claim_req;
  logic [NUM_SRC-1:0] set_vec, clr_vec, w1c_vec, pend_next, insv_next;
  logic               claim_valid;
  logic [ID_W-1:0]    claim_id;
  logic [31:0]        rd_val;

  assign addr      = reg_addr_e'(cfg_addr_i);
  assign cpl_hit   = cfg_we_i && (addr == REG_CLAIM);
  assign claim_hit = cfg_re_i && (addr == REG_CLAIM);
  assign cpl_id    = cfg_wdata_i[ID_W-1:0];

  // Complete is resolved before claim so the completed source can be
  // re-claimed in the same cycle. Non-external IDs never match a mask bit.
  always_comb begin
    cpl_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cpl_vec[i] = cpl_hit && EXT_MASK[i] && (cpl_id == ID_W'(i));
    end
  end

  assign insv_after_cpl = insv & ~cpl_vec;
  assign claim_req      = pend & en & ~insv_after_cpl & EXT_MASK;

  user_irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req   (claim_req),
    .valid (claim_valid),
    .id    (claim_id)
  );

  always_comb begin
    claim_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_vec[i] = claim_hit && claim_valid && (claim_id == ID_W'(i));
    end
  end

  assign insv_next = insv_after_cpl | claim_vec;

  // Pending: set beats every clear. Level sources self-clear only when the
  // input is low and the source is not in service, so an in-service level
  // source stays pending until its complete. W1C on a still-high level
  // source is overridden by the set term.
  assign w1c_vec   = (cfg_we_i && (addr == REG_PEND)) ? cfg_wdata_i[NUM_SRC-1:0] : '0;
  assign set_vec   = (mode & irq_i & ~prev) | (~mode & irq_i);
  assign clr_vec   = (~mode & ~irq_i & ~insv) | w1c_vec | claim_vec;
  assign pend_next = set_vec | (pend & ~clr_vec);

  always_comb begin
    rd_val = '0;
    case (addr)
      REG_EN:    rd_val[NUM_SRC-1:0] = en;
      REG_MODE:  rd_val[NUM_SRC-1:0] = mode;
      REG_PEND:  rd_val[NUM_SRC-1:0] = pend;
      REG_CLAIM: if (claim_valid) rd_val[ID_W-1:0] = claim_id;
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en           <= '0;
      mode         <= '0;
      pend         <= '0;
      insv         <= '0;
      prev         <= '0;
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
    end else begin
      prev         <= irq_i;
      pend         <= pend_next;
      insv         <= insv_next;
      if (cfg_we_i && (addr == REG_EN))   en   <= cfg_wdata_i[NUM_SRC-1:0];
      if (cfg_we_i && (addr == REG_MODE)) mode <= cfg_wdata_i[NUM_SRC-1:0];
      cfg_rvalid_o <= cfg_re_i;
      cfg_rdata_o  <= cfg_re_i ? rd_val : '0;
    end
  end

  assign irq_timer_o    = pend[0] & en[0];
  assign irq_software_o = pend[1] & en[1];
  assign irq_external_o = |(pend & en & ~insv & EXT_MASK);

  for (genvar k = 0; k < 15; k++) begin : g_fast
    if (k < NUM_FAST) begin : g_on
      assign irq_fast_o[k] = pend[k+FAST_BASE] & en[k+FAST_BASE];
    end else begin : g_off
      assign irq_fast_o[k] = 1'b0;
    end
  end

endmodule

// File: doc/user_irq_router.md
Name: user_irq_router

Overview:
- Parametrised interrupt router that sits between the SoC irq bus and a user core's interrupt pins.
- Replaces the fixed mapping (timer/software only, external and fast tied low) with:
  - per-source enable;
  - edge or level mode per source;
  - pending latch;
  - fast-irq fan-out;
  - an external-interrupt claim/complete handshake with in-service gating.
- Configured through a small register port driven by the user core wrapper.

Parameters:
- NUM_SRC, 32, number of irq_i sources (range 3..32).
- NUM_FAST, 15, number of sources routed to irq_fast_o; sources 2..NUM_FAST+1 (range 0..15, NUM_FAST+2 <= NUM_SRC).
- ID_W, $clog2(NUM_SRC), width of the claim ID.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- irq_i  in  NUM_SRC  raw interrupt sources, synchronous to clk_i.
- cfg_we_i  in  1  register write strobe.
- cfg_re_i  in  1  register read strobe.
- cfg_addr_i  in  2  register select: 0 EN, 1 MODE, 2 PEND, 3 CLAIM.
- cfg_wdata_i  in  32  write data.
- cfg_rdata_o  out  32  read data, valid one cycle after cfg_re_i.
- cfg_rvalid_o  out  1  read-data valid pulse.
- irq_timer_o  out  1  from source 0.
- irq_software_o  out  1  from source 1.
- irq_fast_o  out  15  bit k from source k+2; bits >= NUM_FAST are 0.
- irq_external_o  out  1  OR of claimable external sources (index >= NUM_FAST+2).

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - EN, MODE, PEND, in-service (INSV) and prev-sample registers cleared.
  - All outputs 0; cfg_rvalid_o 0, cfg_rdata_o 0.
- Sampling: prev[i] <= irq_i[i] every cycle.
- Pending set condition, evaluated at each edge:
  - edge mode (MODE[i]=1): irq_i[i] & ~prev[i];
  - level mode: irq_i[i].
- Level-mode pending also clears when irq_i[i] is low and no INSV is set for that source.
- Edge-mode pending clears only by W1C on PEND or by claim.
- Set and clear in the same cycle: set wins.
- EN gates outputs only. Disabled sources still latch pending, so enabling later delivers the stored event.
- Outputs are combinational from registers, one cycle after the triggering sample:
  - irq_timer_o = PEND[0]&EN[0];
  - irq_software_o = PEND[1]&EN[1];
  - irq_fast_o[k] = PEND[k+2]&EN[k+2];
  - irq_external_o = |(PEND & EN & ~INSV & EXT_MASK).
- Claim: cfg_re_i with addr 3.
  - Next cycle: cfg_rdata_o = lowest-index external source with PEND&EN&~INSV, zero-extended; 0 when none.
  - Source 0 is never external, so 0 is free to mean "none".
  - Same edge as the claim: PEND of the claimed source clears and its INSV sets.
- Complete: cfg_we_i with addr 3; wdata[ID_W-1:0] selects the source whose INSV clears.
  - IDs that are out of range or non-external are ignored.
- Claim and complete in the same cycle: the complete applies first, so the completed source is eligible for that claim.
- While INSV[i] is set:
  - a level source stays pending but does not raise irq_external_o;
  - an edge source re-latches new edges without raising irq_external_o.
- Register writes:
  - EN and MODE take wdata[NUM_SRC-1:0]; bits >= NUM_SRC read as 0.
  - PEND is write-1-to-clear; it is ineffective on level sources whose input is still high.
- Reads of EN, MODE and PEND return the register value one cycle later with cfg_rvalid_o=1.
- cfg_we_i and cfg_re_i together: the write takes effect, and the read returns the pre-write value.
- Reset mid-claim: the read is dropped, cfg_rvalid_o=0, and all state clears.

Decomposition:
- Package user_irq_pkg holds:
  - the register address enum (REG_EN, REG_MODE, REG_PEND, REG_CLAIM);
  - localparams FAST_BASE=2, EXT_BASE(NUM_FAST);
  - the EXT_MASK generator function.
- Sub-module user_irq_prio_enc: parametrised lowest-index-first priority encoder (NUM_SRC, ID_W) producing {valid, id}. Used for claim.

Test Plan:
- Reset, then EN=0xFFFF_FFFF, MODE=0; drive irq_i[0]=1 → irq_timer_o=1 one cycle later; drive irq_i[0]=0 → irq_timer_o=0 one cycle later.
- MODE[5]=1, EN[5]=1 (irq_fast_o[3]); pulse irq_i[5] for 1 cycle → irq_fast_o[3] stays 1; write PEND=0x20 → irq_fast_o[3]=0 next cycle.
- NUM_FAST=15, level sources 20 and 25 high → irq_external_o=1; claim reads 20 and irq_external_o stays 1 (25); second claim reads 25 and irq_external_o goes 0; third claim reads 0.
- Complete with wdata=20 while irq_i[20] is still high → irq_external_o=1 again next cycle, and a claim returns 20.
- EN=0, edge source 3 pulsed → output stays 0; then write EN[3]=1 → irq_fast_o[1]=1 next cycle (stored event).
- Assert rst_i in the cycle after a claim read → cfg_rvalid_o=0; all outputs 0 and EN/MODE/PEND read 0 afterwards.
